// File: rtl/sonar_array.sv
// -----------------------------------------------------------------------------
// sonar_array
// Ranging controller for N_CH ultrasonic sonars on one clock. Fires trigger
// pulses (all channels together, or one channel per ping in round-robin order),
// measures each echo pulse width in clock cycles on the synchronised echo, and
// publishes a per-channel range with a one-cycle valid strobe and a sticky
// timeout flag.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   en         in   run enable, sampled in IDLE only
//   seq_mode   in   0 = simultaneous firing, 1 = round-robin (sampled in IDLE)
//   echo       in   [N_CH] raw asynchronous echo inputs
//   trig       out  [N_CH] trigger outputs
//   range_flat out  [N_CH*RANGE_W] channel i range at [i*RANGE_W +: RANGE_W]
//   valid      out  [N_CH] one-cycle strobe when channel i range updates
//   tout       out  [N_CH] channel i last result was a timeout
//   busy       out  high whenever the controller is not in IDLE
//   cur_ch     out  channel used by the current or next round-robin ping
//
// Optional feature: define SONAR_AVG_EN to publish a 2-sample running average
// instead of the raw count. Timeouts bypass the filter and restart it.
// -----------------------------------------------------------------------------
module sonar_array #(
    parameter int N_CH           = 3,
    parameter int RANGE_W        = 20,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HOLDOFF_CYCLES = 100000,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      seq_mode,
    input  logic [N_CH-1:0]           echo,
    output logic [N_CH-1:0]           trig,
    output logic [N_CH*RANGE_W-1:0]   range_flat,
    output logic [N_CH-1:0]           valid,
    output logic [N_CH-1:0]           tout,
    output logic                      busy,
    output logic [CH_W-1:0]           cur_ch
);

    localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [TRIG_W-1:0]  TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [RANGE_W-1:0] WIN_LIMIT = RANGE_W'(TIMEOUT_CYCLES);
    localparam logic [RANGE_W-1:0] RANGE_MAX = {RANGE_W{1'b1}};
    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRIG    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CH_WAIT_RISE = 2'd0,
        CH_COUNT     = 2'd1,
        CH_DONE      = 2'd2
    } ch_state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [N_CH-1:0]        mask_q, mask_d;
    logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
    logic [N_CH-1:0]        trig_q, trig_d;
    logic [TRIG_W-1:0]      trig_cnt_q, trig_cnt_d;
    logic [RANGE_W-1:0]     win_cnt_q, win_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [N_CH*RANGE_W-1:0] range_q, range_d;
    logic [N_CH-1:0]        valid_q, valid_d;
    logic [N_CH-1:0]        tout_q, tout_d;
    logic                   busy_q, busy_d;
    ch_state_t              ch_state_q [N_CH];
    ch_state_t              ch_state_d [N_CH];
    logic [RANGE_W-1:0]     count_q [N_CH];
    logic [RANGE_W-1:0]     count_d [N_CH];
`ifdef SONAR_AVG_EN
    logic [N_CH-1:0]        first_q, first_d;
`endif

    // Echo synchroniser (two flops) plus a third stage for edge detection.
    logic [N_CH-1:0]        echo_s1_q, echo_s2_q, echo_s3_q;
    logic [N_CH-1:0]        rise_s, fall_s;
    logic [N_CH-1:0]        onehot_s;
    logic [RANGE_W-1:0]     win_next_s;
    logic                   timeout_hit_s;
    logic                   all_done_s;

`ifdef SONAR_AVG_EN
    // Rounded mean of two samples using a sum one bit wider than the range.
    function automatic logic [RANGE_W-1:0] avg2(input logic [RANGE_W-1:0] a,
                                               input logic [RANGE_W-1:0] b);
        logic [RANGE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{RANGE_W{1'b0}}, 1'b1};
        return sum[RANGE_W:1];
    endfunction
`endif

    // Edge detection on the synchronised echo.
    always_comb begin
        rise_s = echo_s2_q & ~echo_s3_q;
        fall_s = ~echo_s2_q & echo_s3_q;
    end

    // One-hot mask for the round-robin channel.
    always_comb begin
        onehot_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (cur_ch_q == CH_W'(i)) begin
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // Main controller: top-level FSM plus per-channel measurement sub-states.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        mask_d        = mask_q;
        cur_ch_d      = cur_ch_q;
        trig_d        = trig_q;
        trig_cnt_d    = trig_cnt_q;
        win_cnt_d     = win_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        range_d       = range_q;
        valid_d       = {N_CH{1'b0}};
        tout_d        = tout_q;
        win_next_s    = win_cnt_q + RANGE_W'(1);
        timeout_hit_s = 1'b0;
        all_done_s    = 1'b1;
`ifdef SONAR_AVG_EN
        first_d       = first_q;
`endif
        for (int i = 0; i < N_CH; i++) begin
            ch_state_d[i] = ch_state_q[i];
            count_d[i]    = count_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    mode_d     = seq_mode;
                    mask_d     = seq_mode ? onehot_s : {N_CH{1'b1}};
                    trig_d     = seq_mode ? onehot_s : {N_CH{1'b1}};
                    trig_cnt_d = {TRIG_W{1'b0}};
                    state_d    = ST_TRIG;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_TRIG: begin
                if (trig_cnt_q == TRIG_LAST) begin
                    trig_d    = {N_CH{1'b0}};
                    win_cnt_d = {RANGE_W{1'b0}};
                    state_d   = ST_MEASURE;
                    // Channels outside the mask start DONE so they never update.
                    for (int i = 0; i < N_CH; i++) begin
                        ch_state_d[i] = mask_q[i] ? CH_WAIT_RISE : CH_DONE;
                        count_d[i]    = {RANGE_W{1'b0}};
                    end
                end else begin
                    trig_cnt_d = trig_cnt_q + TRIG_W'(1);
                end
            end

            ST_MEASURE: begin
                win_cnt_d     = win_next_s;
                timeout_hit_s = (win_next_s == WIN_LIMIT);
                for (int i = 0; i < N_CH; i++) begin
                    case (ch_state_q[i])
                        CH_WAIT_RISE: begin
                            if (timeout_hit_s) begin
                                range_d[i*RANGE_W +: RANGE_W] = RANGE_MAX;
                                tout_d[i]     = 1'b1;
                                valid_d[i]    = 1'b1;
                                ch_state_d[i] = CH_DONE;
`ifdef SONAR_AVG_EN
                                first_d[i]    = 1'b1;
`endif
                            end else if (rise_s[i]) begin
                                // The rise cycle is the first high cycle.
                                count_d[i]    = RANGE_W'(1);
                                ch_state_d[i] = CH_COUNT;
                            end else begin
                                ch_state_d[i] = CH_WAIT_RISE;
                            end
                        end
                        CH_COUNT: begin
                            // A fall in the timeout cycle still reports the real width.
                            if (fall_s[i]) begin
`ifdef SONAR_AVG_EN
                                if (first_q[i]) begin
                                    range_d[i*RANGE_W +: RANGE_W] = count_q[i];
                                end else begin
                                    range_d[i*RANGE_W +: RANGE_W] =
                                        avg2(range_q[i*RANGE_W +: RANGE_W], count_q[i]);
                                end
                                first_d[i]    = 1'b0;
`else
                                range_d[i*RANGE_W +: RANGE_W] = count_q[i];
`endif
                                tout_d[i]     = 1'b0;
                                valid_d[i]    = 1'b1;
                                ch_state_d[i] = CH_DONE;
                            end else if (timeout_hit_s) begin
                                range_d[i*RANGE_W +: RANGE_W] = RANGE_MAX;
                                tout_d[i]     = 1'b1;
                                valid_d[i]    = 1'b1;
                                ch_state_d[i] = CH_DONE;
`ifdef SONAR_AVG_EN
                                first_d[i]    = 1'b1;
`endif
                            end else if (echo_s2_q[i] && (count_q[i] != RANGE_MAX)) begin
                                count_d[i] = count_q[i] + RANGE_W'(1);
                            end else begin
                                count_d[i] = count_q[i];
                            end
                        end
                        CH_DONE: begin
                            ch_state_d[i] = CH_DONE;
                        end
                        default: begin
                            ch_state_d[i] = CH_DONE;
                        end
                    endcase
                    if (ch_state_d[i] != CH_DONE) begin
                        all_done_s = 1'b0;
                    end else begin
                        all_done_s = all_done_s;
                    end
                end
                if (timeout_hit_s || all_done_s) begin
                    hold_cnt_d = {HOLD_W{1'b0}};
                    state_d    = ST_HOLDOFF;
                end else begin
                    state_d    = ST_MEASURE;
                end
            end

            ST_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    if (mode_q) begin
                        cur_ch_d = (cur_ch_q == CH_LAST) ? {CH_W{1'b0}} : cur_ch_q + CH_W'(1);
                    end else begin
                        cur_ch_d = cur_ch_q;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                trig_d  = {N_CH{1'b0}};
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            mask_q     <= {N_CH{1'b0}};
            cur_ch_q   <= {CH_W{1'b0}};
            trig_q     <= {N_CH{1'b0}};
            trig_cnt_q <= {TRIG_W{1'b0}};
            win_cnt_q  <= {RANGE_W{1'b0}};
            hold_cnt_q <= {HOLD_W{1'b0}};
            range_q    <= {(N_CH*RANGE_W){1'b0}};
            valid_q    <= {N_CH{1'b0}};
            tout_q     <= {N_CH{1'b0}};
            busy_q     <= 1'b0;
            echo_s1_q  <= {N_CH{1'b0}};
            echo_s2_q  <= {N_CH{1'b0}};
            echo_s3_q  <= {N_CH{1'b0}};
`ifdef SONAR_AVG_EN
            first_q    <= {N_CH{1'b1}};
`endif
            for (int i = 0; i < N_CH; i++) begin
                ch_state_q[i] <= CH_DONE;
                count_q[i]    <= {RANGE_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            cur_ch_q   <= cur_ch_d;
            trig_q     <= trig_d;
            trig_cnt_q <= trig_cnt_d;
            win_cnt_q  <= win_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            range_q    <= range_d;
            valid_q    <= valid_d;
            tout_q     <= tout_d;
            busy_q     <= busy_d;
            echo_s1_q  <= echo;
            echo_s2_q  <= echo_s1_q;
            echo_s3_q  <= echo_s2_q;
`ifdef SONAR_AVG_EN
            first_q    <= first_d;
`endif
            for (int i = 0; i < N_CH; i++) begin
                ch_state_q[i] <= ch_state_d[i];
                count_q[i]    <= count_d[i];
            end
        end
    end

    assign trig       = trig_q;
    assign range_flat = range_q;
    assign valid      = valid_q;
    assign tout       = tout_q;
    assign busy       = busy_q;
    assign cur_ch     = cur_ch_q;

endmodule
